// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if
//   Bundles the data-path signals of spike_rate_decoder.
//   master : drives en, spikes, rd_sel; observes results (upstream/readout side)
//   slave  : the decoder itself
//   Signals:
//     en          count enable
//     spikes      per-cycle spike vector, bit i = neuron i fired
//     rd_sel      readout select into snapshot bank
//     winner      index of max-count neuron, last completed window
//     winner_cnt  spike count of winner
//     any_spike   winner_cnt != 0
//     done        one-cycle pulse when results update
//     rd_cnt      snapshot count of neuron rd_sel
//     ovf         per-neuron saturation flags (only with SPIKE_OVF_EN)
interface spike_rate_decoder_if #(
    parameter int unsigned N_NEURONS = 8,
    parameter int unsigned CNT_W     = 7
);
    localparam int unsigned IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                 en;
    logic [N_NEURONS-1:0] spikes;
    logic [IDX_W-1:0]     rd_sel;
    logic [IDX_W-1:0]     winner;
    logic [CNT_W-1:0]     winner_cnt;
    logic                 any_spike;
    logic                 done;
    logic [CNT_W-1:0]     rd_cnt;
`ifdef SPIKE_OVF_EN
    logic [N_NEURONS-1:0] ovf;
`endif

    modport master (
        output en, spikes, rd_sel,
`ifdef SPIKE_OVF_EN
        input  ovf,
`endif
        input  winner, winner_cnt, any_spike, done, rd_cnt
    );

    modport slave (
        input  en, spikes, rd_sel,
`ifdef SPIKE_OVF_EN
        output ovf,
`endif
        output winner, winner_cnt, any_spike, done, rd_cnt
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Counts spikes per neuron over a window of WINDOW enabled cycles, snapshots
//   the counts at the window end, then scans the snapshot one entry per cycle
//   to find the neuron with the highest count (ties -> lowest index) and
//   publishes winner / winner_cnt / any_spike with a one-cycle done pulse.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  spike_rate_decoder_if.slave (en, spikes, rd_sel in; results out)
//   Optional feature: define SPIKE_OVF_EN to add per-neuron saturation flags
//   (bus.ovf), captured into the snapshot bank with the counts.
module spike_rate_decoder #(
    parameter int unsigned N_NEURONS = 8,
    parameter int unsigned WINDOW    = 64,
    parameter int unsigned CNT_W     = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    spike_rate_decoder_if.slave    bus
);
    localparam int unsigned IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t                          state_q, state_d;
    logic [WIN_W-1:0]                win_q, win_d;
    logic [N_NEURONS-1:0][CNT_W-1:0] cnt_q, cnt_d, snap_q, snap_d, cnt_inc;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [IDX_W-1:0]                best_idx_q, best_idx_d;
    logic [CNT_W-1:0]                best_cnt_q, best_cnt_d;
    logic [IDX_W-1:0]                winner_q, winner_d;
    logic [CNT_W-1:0]                winner_cnt_q, winner_cnt_d;
    logic                            any_q, any_d;
    logic                            done_q, done_d;
    logic                            boundary;
    logic [IDX_W-1:0]                new_idx;
    logic [CNT_W-1:0]                new_cnt;

    assign boundary = bus.en && (win_q == WIN_W'(WINDOW - 1));

    // Saturating per-neuron increment; also the value captured at the boundary,
    // so the last cycle's spikes land in the snapshot.
    always_comb begin
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            cnt_inc[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX
                       : cnt_q[i] + {{(CNT_W-1){1'b0}}, bus.spikes[i]};
        end
    end

    always_comb begin
        win_d  = win_q;
        cnt_d  = cnt_q;
        snap_d = snap_q;
        if (bus.en) begin
            if (boundary) begin
                win_d  = '0;
                cnt_d  = '0;
                snap_d = cnt_inc;
            end else begin
                win_d = win_q + 1'b1;
                cnt_d = cnt_inc;
            end
        end
    end

    // Argmax scan: strict '>' keeps the lowest index on ties.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        best_idx_d   = best_idx_q;
        best_cnt_d   = best_cnt_q;
        winner_d     = winner_q;
        winner_cnt_d = winner_cnt_q;
        any_d        = any_q;
        done_d       = 1'b0;
        new_idx      = best_idx_q;
        new_cnt      = best_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (boundary) begin
                    state_d    = S_SCAN;
                    idx_d      = '0;
                    best_idx_d = '0;
                    best_cnt_d = '0;
                end
            end
            S_SCAN: begin
                if (snap_q[idx_q] > best_cnt_q) begin
                    new_idx = idx_q;
                    new_cnt = snap_q[idx_q];
                end
                best_idx_d = new_idx;
                best_cnt_d = new_cnt;
                if (idx_q == IDX_W'(N_NEURONS - 1)) begin
                    winner_d     = new_idx;
                    winner_cnt_d = new_cnt;
                    any_d        = (new_cnt != '0);
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            win_q        <= '0;
            cnt_q        <= '0;
            snap_q       <= '0;
            idx_q        <= '0;
            best_idx_q   <= '0;
            best_cnt_q   <= '0;
            winner_q     <= '0;
            winner_cnt_q <= '0;
            any_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            idx_q        <= idx_d;
            best_idx_q   <= best_idx_d;
            best_cnt_q   <= best_cnt_d;
            winner_q     <= winner_d;
            winner_cnt_q <= winner_cnt_d;
            any_q        <= any_d;
            done_q       <= done_d;
        end
    end

    assign bus.winner     = winner_q;
    assign bus.winner_cnt = winner_cnt_q;
    assign bus.any_spike  = any_q;
    assign bus.done       = done_q;
    assign bus.rd_cnt     = ({1'b0, bus.rd_sel} < (IDX_W+1)'(N_NEURONS))
                          ? snap_q[bus.rd_sel] : '0;

`ifdef SPIKE_OVF_EN
    logic [N_NEURONS-1:0] flag_q, flag_d, snap_ovf_q, snap_ovf_d, sat_hit;

    // A flag is raised when a spike arrives while the counter is already at max.
    always_comb begin
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            sat_hit[i] = bus.spikes[i] && (cnt_q[i] == CNT_MAX);
        end
        flag_d     = flag_q;
        snap_ovf_d = snap_ovf_q;
        if (bus.en) begin
            if (boundary) begin
                flag_d     = '0;
                snap_ovf_d = flag_q | sat_hit;
            end else begin
                flag_d = flag_q | sat_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q     <= '0;
            snap_ovf_q <= '0;
        end else begin
            flag_q     <= flag_d;
            snap_ovf_q <= snap_ovf_d;
        end
    end

    assign bus.ovf = snap_ovf_q;
`endif
endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;
    localparam int unsigned N   = 8;
    localparam int unsigned WIN = 16;
    localparam int unsigned CW  = 4;

    typedef struct {
        logic [7:0][4:0] n;        // spikes per neuron in the window (first n cycles)
        int              exp_win;
        int              exp_cnt;
        int              exp_any;
        int              rd_sel;
        int              exp_rd;
        logic [7:0]      exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spike_rate_decoder_if #(.N_NEURONS(N), .CNT_W(CW)) bus ();

    spike_rate_decoder #(.N_NEURONS(N), .WINDOW(WIN), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [7:0] s);
        bus.en     = e;
        bus.spikes = s;
        @(posedge clk);
        #1;
    endtask

    // Steps with en=0 until done is seen; returns edges taken (0 on timeout).
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 8'h00);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, lat, N);
        if (lat != 0) begin
            step(1'b0, 8'h00);
            check({name, "_done_width"}, int'(bus.done), 0);
        end
    endtask

    task automatic check_result(input string name, input int w, input int c, input int a);
        check({name, "_winner"}, int'(bus.winner), w);
        check({name, "_winner_cnt"}, int'(bus.winner_cnt), c);
        check({name, "_any_spike"}, int'(bus.any_spike), a);
    endtask

    vec_t vecs[6];

    initial begin
        int         lat;
        int         dones;
        logic [7:0] s;

        for (int i = 0; i < 6; i++) begin
            vecs[i].n       = '0;
            vecs[i].exp_ovf = 8'h00;
        end
        // all silent
        vecs[0].exp_win = 0; vecs[0].exp_cnt = 0;  vecs[0].exp_any = 0; vecs[0].rd_sel = 3; vecs[0].exp_rd = 0;
        // neuron 2 every cycle: saturates
        vecs[1].n[2] = 16;
        vecs[1].exp_win = 2; vecs[1].exp_cnt = 15; vecs[1].exp_any = 1; vecs[1].rd_sel = 2; vecs[1].exp_rd = 15;
        vecs[1].exp_ovf = 8'h04;
        // tie 5/1 -> lowest index
        vecs[2].n[5] = 6; vecs[2].n[1] = 6; vecs[2].n[7] = 3;
        vecs[2].exp_win = 1; vecs[2].exp_cnt = 6;  vecs[2].exp_any = 1; vecs[2].rd_sel = 7; vecs[2].exp_rd = 3;
        vecs[3].n[0] = 1; vecs[3].n[6] = 9;
        vecs[3].exp_win = 6; vecs[3].exp_cnt = 9;  vecs[3].exp_any = 1; vecs[3].rd_sel = 0; vecs[3].exp_rd = 1;
        // everything saturates, all tie -> neuron 0
        for (int i = 0; i < 8; i++) vecs[4].n[i] = 16;
        vecs[4].exp_win = 0; vecs[4].exp_cnt = 15; vecs[4].exp_any = 1; vecs[4].rd_sel = 7; vecs[4].exp_rd = 15;
        vecs[4].exp_ovf = 8'hFF;
        // reaching max exactly is not an overflow
        vecs[5].n[3] = 15; vecs[5].n[4] = 14;
        vecs[5].exp_win = 3; vecs[5].exp_cnt = 15; vecs[5].exp_any = 1; vecs[5].rd_sel = 4; vecs[5].exp_rd = 14;

        // Reset
        bus.rd_sel = '0;
        rst = 1'b1;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rst = 1'b0;
        step(1'b0, 8'h00);
        check("rst_winner", int'(bus.winner), 0);
        check("rst_winner_cnt", int'(bus.winner_cnt), 0);
        check("rst_any_spike", int'(bus.any_spike), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_rd_cnt", int'(bus.rd_cnt), 0);

        // Table-driven windows
        for (int v = 0; v < 6; v++) begin
            bus.rd_sel = 3'(vecs[v].rd_sel);
            for (int c = 0; c < int'(WIN); c++) begin
                for (int i = 0; i < 8; i++) s[i] = (c < int'(vecs[v].n[i]));
                step(1'b1, s);
            end
            check($sformatf("v%0d_rd_cnt_at_T", v), int'(bus.rd_cnt), vecs[v].exp_rd);
            wait_done($sformatf("v%0d", v), lat);
            check_result($sformatf("v%0d", v), vecs[v].exp_win, vecs[v].exp_cnt, vecs[v].exp_any);
`ifdef SPIKE_OVF_EN
            check($sformatf("v%0d_ovf", v), int'(bus.ovf), int'(vecs[v].exp_ovf));
`endif
        end

        // en=0 gap mid-window with all neurons firing: ignored, boundary delayed
        dones = 0;
        for (int c = 0; c < 4; c++) begin step(1'b1, 8'h20); dones += int'(bus.done); end
        for (int c = 0; c < 4; c++) begin step(1'b1, 8'h00); dones += int'(bus.done); end
        for (int c = 0; c < 10; c++) begin step(1'b0, 8'hFF); dones += int'(bus.done); end
        for (int c = 0; c < 3; c++) begin step(1'b1, 8'h20); dones += int'(bus.done); end
        for (int c = 0; c < 5; c++) begin step(1'b1, 8'h00); dones += int'(bus.done); end
        check("gap_no_early_done", dones, 0);
        wait_done("gap", lat);
        check_result("gap", 5, 7, 1);
`ifdef SPIKE_OVF_EN
        check("gap_ovf", int'(bus.ovf), 0);
`endif

        // Spike on last cycle of window A, then first cycle of window B
        for (int c = 0; c < 15; c++) step(1'b1, 8'h00);
        step(1'b1, 8'h08);
        step(1'b1, 8'h10);
        for (int c = 0; c < 7; c++) step(1'b1, 8'h00);
        check("winA_done", int'(bus.done), 1);
        check_result("winA", 3, 1, 1);
        for (int c = 0; c < 8; c++) step(1'b1, 8'h00);
        wait_done("winB", lat);
        check_result("winB", 4, 1, 1);

        // Reset at T+4 aborts the scan
        bus.rd_sel = 3'd6;
        for (int c = 0; c < 5; c++) step(1'b1, 8'h40);
        for (int c = 0; c < 11; c++) step(1'b1, 8'h00);
        for (int c = 0; c < 3; c++) step(1'b0, 8'h00);
        rst = 1'b1;
        step(1'b0, 8'h00);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin step(1'b0, 8'h00); dones += int'(bus.done); end
        check("abort_no_done", dones, 0);
        check_result("abort", 0, 0, 0);
        check("abort_rd_cnt", int'(bus.rd_cnt), 0);
`ifdef SPIKE_OVF_EN
        check("abort_ovf", int'(bus.ovf), 0);
`endif
        // Next window must start from win_cnt=0
        bus.rd_sel = 3'd2;
        for (int c = 0; c < 2; c++) step(1'b1, 8'h04);
        for (int c = 0; c < 14; c++) step(1'b1, 8'h00);
        check("post_rst_rd_cnt", int'(bus.rd_cnt), 2);
        wait_done("post_rst", lat);
        check_result("post_rst", 2, 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
